// File: rtl/debug_command_initiator_pkg.sv
// debug_command_initiator_pkg: debug protocol opcodes, initiator state encodings and response status codes
package debug_command_initiator_pkg;
  localparam logic [7:0] op_PING = 8'h01;
  localparam logic [7:0] op_HALT = 8'h02;
  localparam logic [7:0] op_RESUME = 8'h03;
  localparam logic [7:0] PING_RESPONSE_BYTE = 8'hA5;
  localparam logic [2:0] s_INIT_IDLE = 3'd0;
  localparam logic [2:0] s_INIT_SEND = 3'd1;
  localparam logic [2:0] s_INIT_WAIT_TX = 3'd2;
  localparam logic [2:0] s_INIT_WAIT_RSP = 3'd3;
  localparam logic [2:0] s_INIT_REPORT = 3'd4;
  localparam logic [1:0] RSP_OK = 2'd0;
  localparam logic [1:0] RSP_TIMEOUT = 2'd1;
  localparam logic [1:0] RSP_BAD_RESPONSE = 2'd2;
endpackage

// File: rtl/debug_timeout_counter.sv
// debug_timeout_counter: non-wrapping response timer; o_Expired marks the last allowed cycle
module debug_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic i_Clock,
  input  logic i_Reset_N,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expired
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] count_q, count_d;
  always_comb count_d = i_Clear ? '0 : (i_Enable && count_q != TW'(TIMEOUT_CYCLES)) ? count_q + 1'b1 : count_q;
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N) count_q <= '0;
    else count_q <= count_d;
  end
  assign o_Expired = count_q == TW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/debug_command_initiator.sv
// debug_command_initiator: sends debug opcodes over UART and collects PING replies.
// Define DEBUG_INITIATOR_RETRY_EN to resend a timed-out PING up to MAX_RETRIES times.
module debug_command_initiator
  import debug_command_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
`ifdef DEBUG_INITIATOR_RETRY_EN
  , parameter int MAX_RETRIES = 2
`endif
) (
  input  logic       i_Clock,
  input  logic       i_Reset_N,
  input  logic       i_Cmd_Valid,
  output logic       o_Cmd_Ready,
  input  logic [7:0] i_Cmd_Op,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Done,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Rsp_Valid,
  output logic [1:0] o_Rsp_Status,
  output logic [7:0] o_Rsp_Byte,
  output logic [7:0] o_Stray_Count
);
  logic [2:0] state_q, state_d;
  logic [7:0] op_q, op_d, rsp_byte_q, rsp_byte_d, stray_q, stray_d;
  logic [1:0] rsp_status_q, rsp_status_d;
  logic expired;
`ifdef DEBUG_INITIATOR_RETRY_EN
  localparam int RW = $clog2(MAX_RETRIES + 2);
  logic [RW-1:0] retry_q, retry_d;
`endif
  // The timer only runs while awaiting a reply and restarts on every entry to WAIT_RSP.
  debug_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .i_Clock  (i_Clock),
    .i_Reset_N(i_Reset_N),
    .i_Clear  (state_q != s_INIT_WAIT_RSP),
    .i_Enable (state_q == s_INIT_WAIT_RSP),
    .o_Expired(expired)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    rsp_status_d = rsp_status_q;
    rsp_byte_d = rsp_byte_q;
    stray_d = (i_Rx_DV && state_q != s_INIT_WAIT_RSP && stray_q != 8'hFF) ? stray_q + 8'd1 : stray_q;
`ifdef DEBUG_INITIATOR_RETRY_EN
    retry_d = state_q == s_INIT_IDLE ? '0 : retry_q;
`endif
    case (state_q)
      s_INIT_IDLE: if (i_Cmd_Valid) begin
        op_d = i_Cmd_Op;
        state_d = s_INIT_SEND;
      end
      s_INIT_SEND: state_d = s_INIT_WAIT_TX;
      s_INIT_WAIT_TX: if (i_Tx_Done) begin
        state_d = op_q == op_PING ? s_INIT_WAIT_RSP : s_INIT_REPORT;
        if (op_q != op_PING) begin
          rsp_status_d = RSP_OK;
          rsp_byte_d = 8'h00;
        end
      end
      s_INIT_WAIT_RSP: if (i_Rx_DV) begin
        state_d = s_INIT_REPORT;
        rsp_byte_d = i_Rx_Byte;
        rsp_status_d = i_Rx_Byte == PING_RESPONSE_BYTE ? RSP_OK : RSP_BAD_RESPONSE;
      end else if (expired) begin
`ifdef DEBUG_INITIATOR_RETRY_EN
        if (retry_q < RW'(MAX_RETRIES)) begin
          retry_d = retry_q + 1'b1;
          state_d = s_INIT_SEND;
        end else
`endif
        begin
          state_d = s_INIT_REPORT;
          rsp_status_d = RSP_TIMEOUT;
          rsp_byte_d = 8'h00;
        end
      end
      default: state_d = s_INIT_IDLE;
    endcase
  end
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N) begin
      state_q <= s_INIT_IDLE;
      op_q <= 8'h00;
      rsp_status_q <= RSP_OK;
      rsp_byte_q <= 8'h00;
      stray_q <= 8'h00;
`ifdef DEBUG_INITIATOR_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      rsp_status_q <= rsp_status_d;
      rsp_byte_q <= rsp_byte_d;
      stray_q <= stray_d;
`ifdef DEBUG_INITIATOR_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end
  assign o_Cmd_Ready = state_q == s_INIT_IDLE;
  assign o_Tx_DV = state_q == s_INIT_SEND;
  assign o_Tx_Byte = op_q;
  assign o_Rsp_Valid = state_q == s_INIT_REPORT;
  assign o_Rsp_Status = rsp_status_q;
  assign o_Rsp_Byte = rsp_byte_q;
  assign o_Stray_Count = stray_q;
endmodule
